// File: rtl/delay_scan_sequencer.sv
// delay_scan_sequencer
// Steps the pump-probe delay from a start value by a fixed increment and
// holds each point for a programmed number of complete pulse periods.
//
// Strobe semantics: cmd_go, cmd_abort and cycle_strobe are single-cycle
// qualifiers sampled on every rising clk edge. There is no backpressure:
// a strobe that is not acted upon in the cycle it is seen is dropped.
// delay_valid and done are single-cycle pulses with no ready.
module delay_scan_sequencer #(
  parameter int W  = 32,
  parameter int NW = 16
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic [W-1:0]  cfg_start,
  input  logic [W-1:0]  cfg_step,
  input  logic          cfg_down,
  input  logic [NW-1:0] cfg_points,
  input  logic [NW-1:0] cfg_avg,
  input  logic          cfg_loop,
  input  logic          cmd_go,
  input  logic          cmd_abort,
  input  logic          cycle_strobe,
  output logic [W-1:0]  delay_out,
  output logic          delay_valid,
  output logic [NW-1:0] point_idx,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [1:0]    state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARM   = 2'd1,
    S_DWELL = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [NW-1:0] ONE_N = NW'(1);

  state_t        state;
  logic [NW-1:0] dwell_cnt;

  // Configuration captured on a successful go
  logic [W-1:0]  sh_start;
  logic [W-1:0]  sh_step;
  logic          sh_down;
  logic [NW-1:0] sh_points;
  logic [NW-1:0] sh_avg;
  logic          sh_loop;

  logic [W:0]    next_ext;
  logic          last_point;
  logic          point_complete;

  // Next delay with one extra bit so carry-out / borrow lands in the MSB
  always_comb begin
    next_ext = '0;
    if (sh_down) begin
      next_ext = {1'b0, delay_out} - {1'b0, sh_step};
    end else begin
      next_ext = {1'b0, delay_out} + {1'b0, sh_step};
    end
  end

  assign last_point     = (point_idx == (sh_points - ONE_N));
  assign point_complete = ((dwell_cnt + ONE_N) == sh_avg);
  assign state_dbg      = state;

  // Scan sequencer: state, shadow config and all registered outputs
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= S_IDLE;
      dwell_cnt   <= '0;
      sh_start    <= '0;
      sh_step     <= '0;
      sh_down     <= 1'b0;
      sh_points   <= '0;
      sh_avg      <= '0;
      sh_loop     <= 1'b0;
      delay_out   <= '0;
      delay_valid <= 1'b0;
      point_idx   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      delay_valid <= 1'b0;
      done        <= 1'b0;
      case (state)
        S_IDLE: begin
          // go together with abort is treated as no command at all
          if (cmd_go && !cmd_abort) begin
            if (cfg_points == '0 || cfg_avg == '0) begin
              err <= 1'b1;
            end else begin
              sh_start    <= cfg_start;
              sh_step     <= cfg_step;
              sh_down     <= cfg_down;
              sh_points   <= cfg_points;
              sh_avg      <= cfg_avg;
              sh_loop     <= cfg_loop;
              err         <= 1'b0;
              delay_out   <= cfg_start;
              point_idx   <= '0;
              dwell_cnt   <= '0;
              delay_valid <= 1'b1;
              busy        <= 1'b1;
              state       <= S_ARM;
            end
          end
        end
        S_ARM: begin
          // The partial period running when the point started is discarded
          if (cmd_abort) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else if (cycle_strobe) begin
            dwell_cnt <= '0;
            state     <= S_DWELL;
          end
        end
        S_DWELL: begin
          if (cmd_abort) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else if (cycle_strobe) begin
            if (!point_complete) begin
              dwell_cnt <= dwell_cnt + ONE_N;
            end else if (!last_point) begin
              if (next_ext[W]) begin
                err   <= 1'b1;
                busy  <= 1'b0;
                state <= S_IDLE;
              end else begin
                delay_out   <= next_ext[W-1:0];
                point_idx   <= point_idx + ONE_N;
                dwell_cnt   <= '0;
                delay_valid <= 1'b1;
                state       <= S_ARM;
              end
            end else if (sh_loop) begin
              delay_out   <= sh_start;
              point_idx   <= '0;
              dwell_cnt   <= '0;
              delay_valid <= 1'b1;
              state       <= S_ARM;
            end else begin
              done  <= 1'b1;
              state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          // done has already pulsed; delay_out keeps the last point
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_delay_scan_sequencer.sv
// Bench for delay_scan_sequencer: directed scenarios plus randomized scans,
// checked against a transaction-level scan model.
module tb_delay_scan_sequencer;

  localparam int W  = 32;
  localparam int NW = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #2.5 clk = ~clk;

  logic [W-1:0]  cfg_start = '0;
  logic [W-1:0]  cfg_step = '0;
  logic          cfg_down = 1'b0;
  logic [NW-1:0] cfg_points = '0;
  logic [NW-1:0] cfg_avg = '0;
  logic          cfg_loop = 1'b0;
  logic          cmd_go = 1'b0;
  logic          cmd_abort = 1'b0;
  logic          cycle_strobe = 1'b0;
  logic [W-1:0]  delay_out;
  logic          delay_valid;
  logic [NW-1:0] point_idx;
  logic          busy;
  logic          done;
  logic          err;
  logic [1:0]    state_dbg;

  delay_scan_sequencer #(.W(W), .NW(NW)) dut (
    .clk(clk), .resetn(resetn),
    .cfg_start(cfg_start), .cfg_step(cfg_step), .cfg_down(cfg_down),
    .cfg_points(cfg_points), .cfg_avg(cfg_avg), .cfg_loop(cfg_loop),
    .cmd_go(cmd_go), .cmd_abort(cmd_abort), .cycle_strobe(cycle_strobe),
    .delay_out(delay_out), .delay_valid(delay_valid), .point_idx(point_idx),
    .busy(busy), .done(done), .err(err), .state_dbg(state_dbg)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] act_q[$];
  int act_t_q[$];
  int exp_done, act_done, done_lag;
  int n_cmp = 0;
  int n_fail = 0;
  int cycles = 0;
  int last_strobe = 0;

  // ---------------- reference model ----------------
  // A scan is a list of points; each point needs avg+1 period boundaries
  // after it starts (the first only closes the partial period).
  bit           m_busy, m_err, m_fin;
  logic [W-1:0] m_delay;
  int           m_idx, m_seen;
  longint       s_start, s_step;
  bit           s_down, s_loop;
  int           s_points, s_avg;

  task automatic model_step(input bit go, input bit abort, input bit strobe);
    longint cur, nxt;
    if (!resetn) begin
      m_busy = 0; m_err = 0; m_fin = 0; m_delay = '0; m_idx = 0; m_seen = 0;
    end else if (!m_busy) begin
      if (go && !abort) begin
        if (cfg_points == 0 || cfg_avg == 0) m_err = 1;
        else begin
          s_start = longint'({32'h0, cfg_start});
          s_step = longint'({32'h0, cfg_step});
          s_down = cfg_down; s_loop = cfg_loop;
          s_points = int'(cfg_points); s_avg = int'(cfg_avg);
          m_err = 0; m_busy = 1; m_fin = 0; m_idx = 0; m_seen = 0;
          m_delay = cfg_start;
          exp_q.push_back(cfg_start);
        end
      end
    end else if (m_fin) begin
      m_busy = 0; m_fin = 0;
    end else if (abort) begin
      m_busy = 0;
    end else if (strobe) begin
      m_seen++;
      if (m_seen == s_avg + 1) begin
        m_seen = 0;
        if (m_idx != s_points - 1) begin
          cur = longint'({32'h0, m_delay});
          nxt = s_down ? cur - s_step : cur + s_step;
          if (nxt < 0 || nxt > 64'sh0FFFF_FFFF) begin
            m_err = 1; m_busy = 0;
          end else begin
            m_delay = nxt[31:0]; m_idx++;
            exp_q.push_back(m_delay);
          end
        end else if (s_loop) begin
          m_delay = s_start[31:0]; m_idx = 0;
          exp_q.push_back(m_delay);
        end else begin
          m_fin = 1; exp_done++;
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input bit go, input bit abort, input bit strobe);
    cmd_go = go; cmd_abort = abort; cycle_strobe = strobe;
    @(posedge clk);
    #1;
    cycles++;
    if (strobe) last_strobe = cycles;
    model_step(go, abort, strobe);
    if (delay_valid) begin
      act_q.push_back(delay_out);
      act_t_q.push_back(cycles);
    end
    if (done) begin
      act_done++;
      done_lag = cycles - last_strobe;
    end
    cmd_go = 0; cmd_abort = 0; cycle_strobe = 0;
  endtask

  task automatic run(input int n, input int period, input int phase);
    for (int i = 0; i < n; i++) tick(0, 0, ((i + phase) % period) == 0);
  endtask

  task automatic set_cfg(input logic [W-1:0] start, input logic [W-1:0] step,
                         input bit down, input int points, input int avg,
                         input bit loop_en);
    cfg_start = start; cfg_step = step; cfg_down = down;
    cfg_points = NW'(points); cfg_avg = NW'(avg); cfg_loop = loop_en;
  endtask

  task automatic clear_sb();
    exp_q.delete(); act_q.delete(); act_t_q.delete();
    exp_done = 0; act_done = 0; done_lag = -1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    resetn = 0;
    tick(1, 0, 1);
    tick(0, 1, 1);
    resetn = 1;
    n_cmp++; if (delay_out !== '0) begin n_fail++; $display("FAIL reset_delay got %h want 0", delay_out); end
    n_cmp++; if ({delay_valid, busy, done, err} !== 4'b0) begin n_fail++; $display("FAIL reset_flags got %b want 0000", {delay_valid, busy, done, err}); end
    n_cmp++; if (point_idx !== '0) begin n_fail++; $display("FAIL reset_idx got %0d want 0", point_idx); end
    n_cmp++; if (state_dbg !== 2'd0) begin n_fail++; $display("FAIL reset_state got %0d want 0", state_dbg); end
  endtask

  task automatic test_basic_scan();
    int period;
    period = $urandom_range(5, 12);
    clear_sb();
    set_cfg(32'd2000, 32'd100, 0, 3, 2, 0);
    tick(1, 0, 0);
    n_cmp++; if (delay_valid !== 1'b1 || busy !== 1'b1 || delay_out !== 32'd2000) begin n_fail++; $display("FAIL go_latency got v=%b b=%b d=%0d want 1 1 2000", delay_valid, busy, delay_out); end
    set_cfg(32'd7, 32'd1, 1, 9, 9, 1);  // must not affect the running scan
    run(12 * period, period, $urandom_range(0, period - 1));
    n_cmp++; if (act_q.size() !== 3) begin n_fail++; $display("FAIL basic_count got %0d want 3", act_q.size()); end
    for (int i = 0; i < 3 && i < act_q.size(); i++) begin
      n_cmp++; if (act_q[i] !== 32'(2000 + 100 * i)) begin n_fail++; $display("FAIL basic_value[%0d] got %0d want %0d", i, act_q[i], 2000 + 100 * i); end
    end
    if (act_t_q.size() >= 3) begin
      n_cmp++; if (act_t_q[2] - act_t_q[1] !== 3 * period) begin n_fail++; $display("FAIL basic_span got %0d want %0d", act_t_q[2] - act_t_q[1], 3 * period); end
    end
    n_cmp++; if (act_done !== 1) begin n_fail++; $display("FAIL basic_done got %0d want 1", act_done); end
    n_cmp++; if (done_lag !== 0) begin n_fail++; $display("FAIL basic_done_lag got %0d want 0", done_lag); end
    n_cmp++; if (delay_out !== 32'd2200 || busy !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL basic_final got d=%0d b=%b e=%b want 2200 0 0", delay_out, busy, err); end
  endtask

  task automatic test_loop_abort();
    logic [W-1:0] held;
    clear_sb();
    set_cfg(32'd2000, 32'd100, 0, 3, 2, 1);
    tick(1, 0, 0);
    run(8 * 3 * 10 + 5, 10, 3);
    n_cmp++; if (act_q.size() !== exp_q.size() || act_q.size() < 8) begin n_fail++; $display("FAIL loop_count got %0d want %0d", act_q.size(), exp_q.size()); end
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
      n_cmp++; if (act_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL loop_value[%0d] got %0d want %0d", i, act_q[i], exp_q[i]); end
    end
    if (act_q.size() > 3) begin
      n_cmp++; if (act_q[3] !== 32'd2000) begin n_fail++; $display("FAIL loop_wrap got %0d want 2000", act_q[3]); end
    end
    n_cmp++; if (act_done !== 0) begin n_fail++; $display("FAIL loop_done got %0d want 0", act_done); end
    held = m_delay;
    tick(0, 1, 1);
    n_cmp++; if (busy !== 1'b0 || delay_out !== held || delay_valid !== 1'b0) begin n_fail++; $display("FAIL loop_abort got b=%b d=%0d v=%b want 0 %0d 0", busy, delay_out, delay_valid, held); end
  endtask

  task automatic test_cfg_error();
    clear_sb();
    set_cfg(32'd50, 32'd5, 0, 0, 2, 0);
    tick(1, 0, 0);
    n_cmp++; if (err !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL err_points got e=%b b=%b want 1 0", err, busy); end
    set_cfg(32'd50, 32'd5, 0, 2, 0, 0);
    tick(1, 0, 0);
    n_cmp++; if (err !== 1'b1 || busy !== 1'b0 || delay_valid !== 1'b0) begin n_fail++; $display("FAIL err_avg got e=%b b=%b v=%b want 1 0 0", err, busy, delay_valid); end
    set_cfg(32'd50, 32'd5, 0, 2, 1, 0);
    tick(1, 1, 0);
    n_cmp++; if (busy !== 1'b0 || err !== 1'b1) begin n_fail++; $display("FAIL go_abort_idle got b=%b e=%b want 0 1", busy, err); end
    tick(1, 0, 0);
    n_cmp++; if (err !== 1'b0 || busy !== 1'b1 || delay_out !== 32'd50) begin n_fail++; $display("FAIL err_clear got e=%b b=%b d=%0d want 0 1 50", err, busy, delay_out); end
    tick(0, 1, 0);
  endtask

  task automatic test_overflow(input bit down);
    logic [W-1:0] st;
    st = down ? 32'h0000_0100 : 32'hFFFF_FF00;
    clear_sb();
    set_cfg(st, 32'h200, down, 2, 1, 0);
    tick(1, 0, 0);
    tick(0, 0, 1);
    tick(0, 0, 1);
    n_cmp++; if (err !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL ovf_flags dn=%0d got e=%b b=%b want 1 0", down, err, busy); end
    n_cmp++; if (delay_out !== st || delay_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_hold dn=%0d got d=%h v=%b want %h 0", down, delay_out, delay_valid, st); end
    run(10, 2, 0);
    n_cmp++; if (act_q.size() !== 1 || act_done !== 0) begin n_fail++; $display("FAIL ovf_events dn=%0d got %0d/%0d want 1/0", down, act_q.size(), act_done); end
  endtask

  task automatic test_coincidence();
    clear_sb();
    set_cfg(32'd300, 32'd10, 0, 3, 1, 0);
    tick(1, 0, 1);          // strobe with go is not counted
    tick(0, 0, 1);          // closes partial period
    n_cmp++; if (act_q.size() !== 1) begin n_fail++; $display("FAIL go_strobe got %0d events want 1", act_q.size()); end
    cfg_start = 32'd9999;
    tick(1, 0, 0);          // go while busy is ignored
    n_cmp++; if (delay_out !== 32'd300 || delay_valid !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL go_busy got d=%0d v=%b b=%b want 300 0 1", delay_out, delay_valid, busy); end
    tick(0, 0, 1);          // completes point 0
    n_cmp++; if (delay_out !== 32'd310 || point_idx !== 16'd1 || delay_valid !== 1'b1) begin n_fail++; $display("FAIL coin_step got d=%0d i=%0d v=%b want 310 1 1", delay_out, point_idx, delay_valid); end
    tick(0, 0, 1);
    tick(0, 1, 1);          // abort beats the completing strobe
    n_cmp++; if (delay_valid !== 1'b0 || busy !== 1'b0 || delay_out !== 32'd310 || point_idx !== 16'd1) begin n_fail++; $display("FAIL abort_strobe got v=%b b=%b d=%0d i=%0d want 0 0 310 1", delay_valid, busy, delay_out, point_idx); end
  endtask

  task automatic test_reset_mid_scan();
    clear_sb();
    set_cfg(32'd2000, 32'd100, 0, 3, 2, 0);
    tick(1, 0, 0);
    run(3, 1, 0);           // point 0 done -> 2100
    tick(0, 0, 1);          // DWELL of point 1
    n_cmp++; if (delay_out !== 32'd2100 || state_dbg !== 2'd2) begin n_fail++; $display("FAIL rst_pre got d=%0d s=%0d want 2100 2", delay_out, state_dbg); end
    resetn = 0;
    tick(1, 0, 1);
    resetn = 1;
    n_cmp++; if (delay_out !== '0 || point_idx !== '0 || {delay_valid, busy, done, err} !== 4'b0) begin n_fail++; $display("FAIL rst_mid got d=%0d i=%0d f=%b want 0 0 0000", delay_out, point_idx, {delay_valid, busy, done, err}); end
    clear_sb();
    tick(1, 0, 0);
    run(40, 4, 1);
    n_cmp++; if (act_q.size() !== 3 || act_done !== 1 || delay_out !== 32'd2200) begin n_fail++; $display("FAIL rst_rerun got n=%0d dn=%0d d=%0d want 3 1 2200", act_q.size(), act_done, delay_out); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 25; it++) begin
      tick(0, 1, 0);
      clear_sb();
      set_cfg($urandom_range(0, 3) == 0 ? 32'hFFFF_F000 + $urandom_range(0, 4095) : $urandom_range(0, 100000),
              $urandom_range(0, 4) == 0 ? $urandom : $urandom_range(0, 1000),
              $urandom_range(0, 1), $urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(0, 1));
      tick(1, 0, $urandom_range(0, 1));
      for (int c = 0; c < 150; c++) begin
        tick($urandom_range(0, 49) == 0, $urandom_range(0, 119) == 0, $urandom_range(0, 3) == 0);
      end
      n_cmp++; if (act_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL rnd_count it=%0d got %0d want %0d", it, act_q.size(), exp_q.size()); end
      for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
        n_cmp++; if (act_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rnd_value it=%0d [%0d] got %h want %h", it, i, act_q[i], exp_q[i]); end
      end
      n_cmp++; if (act_done !== exp_done) begin n_fail++; $display("FAIL rnd_done it=%0d got %0d want %0d", it, act_done, exp_done); end
      n_cmp++; if (delay_out !== m_delay || point_idx !== NW'(m_idx)) begin n_fail++; $display("FAIL rnd_pos it=%0d got %h/%0d want %h/%0d", it, delay_out, point_idx, m_delay, m_idx); end
      n_cmp++; if (busy !== m_busy || err !== m_err) begin n_fail++; $display("FAIL rnd_flags it=%0d got b=%b e=%b want %b %b", it, busy, err, m_busy, m_err); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic_scan();
    test_loop_abort();
    test_cfg_error();
    test_overflow(0);
    test_overflow(1);
    test_coincidence();
    test_reset_mid_scan();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
